reg_window_ctrl: RTL and testbench

- Sequencer for the windowed physical register file: 32×16-bit physical registers, 8-register visible window, windows overlapping by 4.
- Owns the current window base (cwb) and the count of resident windows.
- On call/return it either shifts the window in one cycle, or spills/fills 4 registers to/from a memory stack over a req/ack handshake.
- Sits between the control FSM and the register file / memory interface.

---
 rtl/reg_window_ctrl_pkg.sv | 12 +
 rtl/reg_window_ctrl_xfer.sv | 29 ++
 rtl/reg_window_ctrl.sv | 117 +++++++++++
 tb/tb_reg_window_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_window_ctrl_pkg.sv
// reg_window_pkg: shared state type, window limits and mod-32 window index arithmetic
package reg_window_pkg;
  localparam int IDX_W = 5;
  localparam int MAX_RES = (32 - 8) / 4 + 1;
  typedef enum logic [1:0] {IDLE, SPILL, FILL, FINISH} win_state_t;
  function automatic logic [IDX_W-1:0] win_add(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return a + b;
  endfunction
  function automatic logic [IDX_W-1:0] win_sub(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return a - b;
  endfunction
endpackage

// File: rtl/reg_window_ctrl_xfer.sv
// window_xfer: four-beat req/ack sequencer shared by spill and fill
module window_xfer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        wr_rf,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic [1:0]  beat,
  output logic        last,
  output logic        rf_we,
  output logic [15:0] rf_wdata
);
  logic fire;
  assign fire = mem_req && mem_ack;
  assign last = fire && beat == 2'd3;
  assign rf_we = wr_rf && fire;
  assign rf_wdata = rf_we ? mem_rdata : '0;
  // hold mem_req from start until the fourth accepted beat; a beat advances on each accepted ack
  always_ff @(posedge clock)
    if (reset) begin
      mem_req <= 1'b0;
      beat <= '0;
    end else begin
      mem_req <= start || (mem_req && !last);
      beat <= start ? 2'd0 : beat + 2'(fire);
    end
endmodule

// File: rtl/reg_window_ctrl.sv
// reg_window_ctrl: register-window call/return sequencer with spill/fill; WINCTRL_STATS_EN adds spill_cnt/fill_cnt
module reg_window_ctrl
  import reg_window_pkg::*;
#(
  parameter int          NUM_PHYS   = 32,
  parameter int          WIN_SIZE   = 8,
  parameter int          WIN_STEP   = 4,
  parameter int          DEPTH_W    = 8,
  parameter logic [15:0] STACK_BASE = 16'hF000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             call_req,
  input  logic             ret_req,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] cwb,
  output logic [IDX_W-1:0] rf_sel,
  input  logic [15:0]      rf_rdata,
  output logic [15:0]      rf_wdata,
  output logic             rf_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
`ifdef WINCTRL_STATS_EN
  output logic [15:0]      spill_cnt,
  output logic [15:0]      fill_cnt,
`endif
  input  logic             mem_ack
);
  localparam int MAX_R = (NUM_PHYS - WIN_SIZE) / WIN_STEP + 1;
  localparam logic [IDX_W-1:0] STEP = IDX_W'(WIN_STEP);
  win_state_t state;
  logic fill_dir, idle, go_spill, go_fill, last;
  logic [2:0] res;
  logic [DEPTH_W-1:0] depth;
  logic [1:0] beat;
  logic [IDX_W-1:0] ob;
  assign idle = state == IDLE;
  assign go_spill = idle && call_req && !ret_req && res == 3'(MAX_R) && depth != '1;
  assign go_fill = idle && ret_req && !call_req && res == 3'd1 && depth != '0;
  assign ob = win_sub(cwb, IDX_W'(int'(res - 3'd1) * WIN_STEP));
  assign rf_sel = state == SPILL ? win_add(ob, IDX_W'(beat)) :
                  state == FILL ? win_sub(win_sub(cwb, IDX_W'(1)), IDX_W'(beat)) : '0;
  assign mem_we = state == SPILL;
  assign mem_addr = state == SPILL ? STACK_BASE + 16'({depth, beat}) :
                    state == FILL ? STACK_BASE + 16'({depth - DEPTH_W'(1), ~beat}) : '0;
  assign mem_wdata = state == SPILL ? rf_rdata : '0;
  window_xfer u_xfer (
    .clock    (clock),
    .reset    (reset),
    .start    (go_spill || go_fill),
    .wr_rf    (state == FILL),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .mem_req  (mem_req),
    .beat     (beat),
    .last     (last),
    .rf_we    (rf_we),
    .rf_wdata (rf_wdata)
  );
  // window sequencing: fast shifts in IDLE, spill/fill via the transfer engine, commit in FINISH
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      fill_dir <= 1'b0;
      cwb <= '0;
      res <= 3'd1;
      depth <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE:
          if (go_spill || go_fill) begin
            state <= go_spill ? SPILL : FILL;
            fill_dir <= go_fill;
            busy <= 1'b1;
          end else if (call_req && !ret_req && res != 3'(MAX_R)) begin
            cwb <= win_add(cwb, STEP);
            res <= res + 3'd1;
            done <= 1'b1;
          end else if (ret_req && !call_req && res != 3'd1) begin
            cwb <= win_sub(cwb, STEP);
            res <= res - 3'd1;
            done <= 1'b1;
          end else
            err <= call_req || ret_req;
        SPILL, FILL:
          if (last) state <= FINISH;
        FINISH: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          cwb <= fill_dir ? win_sub(cwb, STEP) : win_add(cwb, STEP);
          depth <= fill_dir ? depth - DEPTH_W'(1) : depth + DEPTH_W'(1);
        end
      endcase
    end
`ifdef WINCTRL_STATS_EN
  // saturating counts of completed spills and fills
  always_ff @(posedge clock)
    if (reset) begin
      spill_cnt <= '0;
      fill_cnt <= '0;
    end else if (state == FINISH) begin
      spill_cnt <= spill_cnt + 16'(!fill_dir && spill_cnt != '1);
      fill_cnt <= fill_cnt + 16'(fill_dir && fill_cnt != '1);
    end
`endif
endmodule

// File: tb/tb_reg_window_ctrl.sv
// tb_reg_window_ctrl: randomized self-checking bench against a window/stack reference model
module tb_reg_window_ctrl;
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [4:0]  sel;
  } xfer_t;
  logic clock = 1'b0;
  logic reset, call_req, ret_req, busy, done, err, rf_we, mem_req, mem_we, mem_ack;
  logic [4:0] cwb, rf_sel;
  logic [15:0] rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] rf [32];
  logic [15:0] mem_m [logic [15:0]];
  xfer_t log_q [$];
  xfer_t xe;
  logic [15:0] saved [$];
  int n_chk, n_err, req_cnt, dly, ack_lim, max_dly;
  int m_cwb, m_res, m_depth;
  bit stray, ld_en;
  logic [4:0] ld_idx;
  logic [15:0] ld_val;
  always #5 clock = ~clock;
  reg_window_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .call_req (call_req),
    .ret_req  (ret_req),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cwb      (cwb),
    .rf_sel   (rf_sel),
    .rf_rdata (rf_rdata),
    .rf_wdata (rf_wdata),
    .rf_we    (rf_we),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );
  assign rf_rdata = rf[rf_sel];
  // physical register file behind the DUT
  always @(posedge clock)
    if (rf_we) rf[rf_sel] <= rf_wdata;
    else if (ld_en) rf[ld_idx] <= ld_val;
  // memory responder: random ack latency, logs every accepted beat
  always @(negedge clock) begin
    if (mem_req) req_cnt++;
    mem_ack = 1'b0;
    if (mem_req && log_q.size() < ack_lim) begin
      if (dly == 0) begin
        mem_ack = 1'b1;
        mem_rdata = mem_we ? 16'($urandom) : (mem_m.exists(mem_addr) ? mem_m[mem_addr] : 16'hDEAD);
        if (mem_we) mem_m[mem_addr] = mem_wdata;
        xe.we = mem_we;
        xe.addr = mem_addr;
        xe.data = mem_we ? mem_wdata : mem_rdata;
        xe.sel = rf_sel;
        log_q.push_back(xe);
        dly = $urandom_range(0, max_dly);
      end else
        dly--;
    end else if (stray && !mem_req)
      mem_ack = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load_rf(input int idx, input logic [15:0] v);
    @(negedge clock);
    ld_en = 1'b1;
    ld_idx = 5'(idx);
    ld_val = v;
    @(negedge clock);
    ld_en = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_cwb = 0;
    m_res = 1;
    m_depth = 0;
    saved.delete();
  endtask
  task automatic op(input bit c, input bit r, input bit poke);
    int kind, ob, cw0, d0, n, sz;
    bit fin, seen_err, drop, moved;
    logic [15:0] win [4];
    logic [15:0] w [4];
    if (c && r) kind = 2;
    else if (c) kind = m_res < 7 ? 0 : (m_depth < 255 ? 3 : 2);
    else kind = m_res > 1 ? 1 : (m_depth > 0 ? 4 : 2);
    if (kind == 4) for (int i = 0; i < 4; i++) load_rf((m_cwb - 4 + i) & 31, 16'($urandom));
    ob = (m_cwb - (m_res - 1) * 4) & 31;
    cw0 = m_cwb;
    d0 = m_depth;
    for (int i = 0; i < 4; i++) win[i] = rf[(ob + i) & 31];
    log_q.delete();
    @(negedge clock);
    call_req = c;
    ret_req = r;
    @(negedge clock);
    call_req = 1'b0;
    ret_req = 1'b0;
    if (kind < 3) begin
      chk("done", done, kind < 2);
      chk("err", err, kind == 2);
      chk("busy", busy, 0);
      m_cwb = kind == 0 ? (m_cwb + 4) & 31 : kind == 1 ? (m_cwb - 4) & 31 : m_cwb;
      m_res += kind == 0 ? 1 : kind == 1 ? -1 : 0;
      chk("cwb", cwb, m_cwb);
    end else begin
      chk("busy_start", busy, 1);
      n = 0;
      fin = 0;
      seen_err = 0;
      drop = 0;
      moved = 0;
      while (n < 400 && !fin) begin
        call_req = poke && n == 1;
        @(negedge clock);
        n++;
        fin = done;
        seen_err |= err;
        if (!done && !busy) drop = 1;
        if (!done && cwb !== 5'(m_cwb)) moved = 1;
      end
      call_req = 1'b0;
      chk("completed", fin, 1);
      chk("busy_held", drop, 0);
      chk("cwb_hold", moved, 0);
      chk("no_err_busy", seen_err, 0);
      chk("busy_end", busy, 0);
      sz = saved.size();
      if (kind == 4) for (int i = 0; i < 4; i++) w[i] = saved[sz - 4 + i];
      m_cwb = kind == 3 ? (m_cwb + 4) & 31 : (m_cwb - 4) & 31;
      m_depth += kind == 3 ? 1 : -1;
      chk("cwb_after", cwb, m_cwb);
      chk("beats", log_q.size(), 4);
      if (log_q.size() == 4) begin
        for (int b = 0; b < 4; b++) begin
          if (kind == 3) begin
            chk("sp_addr", log_q[b].addr, 32'hF000 + d0 * 4 + b);
            chk("sp_we", log_q[b].we, 1);
            chk("sp_data", log_q[b].data, win[b]);
            chk("sp_sel", log_q[b].sel, (ob + b) & 31);
            chk("sp_rf_keep", rf[(ob + b) & 31], win[b]);
          end else begin
            chk("fl_addr", log_q[b].addr, 32'hF000 + (d0 - 1) * 4 + 3 - b);
            chk("fl_we", log_q[b].we, 0);
            chk("fl_data", log_q[b].data, w[3 - b]);
            chk("fl_sel", log_q[b].sel, (cw0 - 1 - b) & 31);
            chk("fl_rf", rf[(cw0 - 4 + b) & 31], w[b]);
          end
        end
      end
      if (kind == 3) for (int i = 0; i < 4; i++) saved.push_back(win[i]);
      else repeat (4) void'(saved.pop_back());
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int n, x;
    reset = 1'b1;
    call_req = 1'b0;
    ret_req = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    ld_en = 1'b0;
    ld_idx = '0;
    ld_val = '0;
    stray = 1'b0;
    ack_lim = 1000;
    max_dly = 2;
    dly = 2;
    n_chk = 0;
    n_err = 0;
    req_cnt = 0;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cwb", cwb, 0);
    chk("rst_rf_sel", rf_sel, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    m_cwb = 0;
    m_res = 1;
    m_depth = 0;
    for (int i = 0; i < 32; i++) load_rf(i, 16'($urandom));
    op(0, 1, 0);
    op(1, 1, 0);
    repeat (6) op(1, 0, 0);
    chk("no_req_fast", req_cnt, 0);
    stray = 1'b1;
    repeat (3) @(negedge clock);
    stray = 1'b0;
    @(negedge clock);
    chk("stray_cwb", cwb, m_cwb);
    chk("stray_done", done, 0);
    chk("stray_busy", busy, 0);
    chk("stray_req", mem_req, 0);
    op(1, 0, 1);
    op(1, 0, 0);
    repeat (8) op(0, 1, 0);
    op(0, 1, 0);
    for (int i = 0; i < 80; i++) begin
      x = $urandom_range(0, 9);
      op(x < 5 || x == 9, x >= 5, 1'($urandom_range(0, 1)));
    end
    do_reset();
    repeat (6) op(1, 0, 0);
    log_q.delete();
    ack_lim = 2;
    @(negedge clock);
    call_req = 1'b1;
    @(negedge clock);
    call_req = 1'b0;
    n = 0;
    while (log_q.size() < 2 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("beat2_reach", log_q.size(), 2);
    @(negedge clock);
    chk("beat2_req", mem_req, 1);
    chk("beat2_busy", busy, 1);
    chk("beat2_addr", mem_addr, 32'hF000 + m_depth * 4 + 2);
    chk("beat2_cwb", cwb, m_cwb);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cwb", cwb, 0);
    chk("abort_addr", mem_addr, 0);
    reset = 1'b0;
    m_cwb = 0;
    m_res = 1;
    m_depth = 0;
    saved.delete();
    ack_lim = 1000;
    op(1, 0, 0);
    op(0, 1, 0);
    op(0, 1, 0);
    do_reset();
    max_dly = 0;
    repeat (6) op(1, 0, 0);
    repeat (256) op(1, 0, 0);
    chk("sat_err_cwb", cwb, m_cwb);
    repeat (7) op(0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
